pcs_transmit_ordered_set: RTL and testbench



---
 rtl/pcs_codes_pkg.sv | 86 ++++++++
 rtl/encoder_8b10b.sv | 57 +++++
 rtl/pcs_transmit_ordered_set.sv | 117 +++++++++++
 tb/tb_pcs_transmit_ordered_set.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_codes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcs_codes_pkg
//  Purpose  : Shared 8b/10b code-group constants, transmit FSM states and
//             the 5b/6b and 3b/4b lookup tables for the 1000BASE-X PCS.
//  Revision : 1.0 - initial release
// ============================================================================
package pcs_codes_pkg;

    // Special code groups, both running-disparity forms, bit 9 = a
    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;
    localparam logic [9:0] K27_7_NEG = 10'b1101101000;
    localparam logic [9:0] K27_7_POS = 10'b0010010111;
    localparam logic [9:0] K29_7_NEG = 10'b1011101000;
    localparam logic [9:0] K29_7_POS = 10'b0100010111;
    localparam logic [9:0] K23_7_NEG = 10'b1110101000;
    localparam logic [9:0] K23_7_POS = 10'b0001010111;
    localparam logic [9:0] K30_7_NEG = 10'b0111101000;
    localparam logic [9:0] K30_7_POS = 10'b1000010111;
    localparam logic [9:0] D5_6_NEG  = 10'b1010010110;
    localparam logic [9:0] D5_6_POS  = 10'b1010010110;
    localparam logic [9:0] D16_2_NEG = 10'b0110110101;
    localparam logic [9:0] D16_2_POS = 10'b1001000101;

    // Octet values {HGF,EDCBA} fed to the encoder for each special group
    localparam logic [7:0] K28_5_BYTE = 8'hBC;
    localparam logic [7:0] K27_7_BYTE = 8'hFB;
    localparam logic [7:0] K29_7_BYTE = 8'hFD;
    localparam logic [7:0] K23_7_BYTE = 8'hF7;
    localparam logic [7:0] K30_7_BYTE = 8'hFE;
    localparam logic [7:0] D5_6_BYTE  = 8'hC5;
    localparam logic [7:0] D16_2_BYTE = 8'h50;

    // K28 uses its own 6b group; the alternate 4b group serves Dx.A7 and Kx.7
    localparam logic [5:0] SIX_K28 = 6'b001111;
    localparam logic [3:0] FOUR_A7 = 4'b0111;

    // Transmit FSM: each state names the group emitted on the next edge
    typedef enum logic [2:0] {
        ST_IDLE_K = 3'd0,
        ST_IDLE_D = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_END_R  = 3'd4,
        ST_END_R2 = 3'd5
    } tx_state_e;

    // 5b/6b table, RD- form (abcdei)
    function automatic logic [5:0] five_to_six(input logic [4:0] x);
        logic [5:0] s;
        case (x)
            5'd0:  s = 6'b100111;  5'd1:  s = 6'b011101;
            5'd2:  s = 6'b101101;  5'd3:  s = 6'b110001;
            5'd4:  s = 6'b110101;  5'd5:  s = 6'b101001;
            5'd6:  s = 6'b011001;  5'd7:  s = 6'b111000;
            5'd8:  s = 6'b111001;  5'd9:  s = 6'b100101;
            5'd10: s = 6'b010101;  5'd11: s = 6'b110100;
            5'd12: s = 6'b001101;  5'd13: s = 6'b101100;
            5'd14: s = 6'b011100;  5'd15: s = 6'b010111;
            5'd16: s = 6'b011011;  5'd17: s = 6'b100011;
            5'd18: s = 6'b010011;  5'd19: s = 6'b110010;
            5'd20: s = 6'b001011;  5'd21: s = 6'b101010;
            5'd22: s = 6'b011010;  5'd23: s = 6'b111010;
            5'd24: s = 6'b110011;  5'd25: s = 6'b100110;
            5'd26: s = 6'b010110;  5'd27: s = 6'b110110;
            5'd28: s = 6'b001110;  5'd29: s = 6'b101110;
            5'd30: s = 6'b011110;  default: s = 6'b101011;
        endcase
        return s;
    endfunction

    // 3b/4b table, RD- form (fghj), primary .7
    function automatic logic [3:0] three_to_four(input logic [2:0] y);
        logic [3:0] f;
        case (y)
            3'd0: f = 4'b1011;  3'd1: f = 4'b1001;
            3'd2: f = 4'b0101;  3'd3: f = 4'b1100;
            3'd4: f = 4'b1101;  3'd5: f = 4'b1010;
            3'd6: f = 4'b0110;  default: f = 4'b1110;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_8b10b.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_8b10b
//  Purpose  : Combinational 8b/10b encoder with running-disparity tracking,
//             alternate 4b (A7) selection and the K28 / Kx.7 rules.
//  Revision : 1.0 - initial release
// ============================================================================
module encoder_8b10b
    import pcs_codes_pkg::*;
(
    input  logic [7:0] data,
    input  logic       is_k,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] six_raw;
    logic [5:0] six;
    logic       six_bal;
    logic       rd_mid;
    logic       use_alt;
    logic [3:0] four_raw;
    logic [3:0] four;
    logic       four_bal;
    logic       four_flip;

    // Encode 6b then 4b; RD- table forms are complemented at RD+ when unbalanced
    always_comb begin
        x        = data[4:0];
        y        = data[7:5];
        six_raw  = (is_k && (x == 5'd28)) ? SIX_K28 : five_to_six(x);
        six_bal  = ($countones(six_raw) == 3);
        // D7 is balanced but still alternates between 111000 and 000111
        six      = (rd_in && (!six_bal || ((x == 5'd7) && !is_k))) ? ~six_raw : six_raw;
        rd_mid   = six_bal ? rd_in : ~rd_in;
        // A7 avoids a run of five identical bits across the sub-block boundary
        use_alt  = (y == 3'd7) &&
                   (is_k || (rd_mid ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                                    : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))));
        four_raw = use_alt ? FOUR_A7 : three_to_four(y);
        four_bal = ($countones(four_raw) == 2);
        // K28.1/.2/.5/.6 invert their balanced 4b group when entered at RD+
        if (is_k && (x == 5'd28) && four_bal && (y != 3'd3)) begin
            four_flip = rd_in;
        end else begin
            four_flip = rd_mid && (!four_bal || (y == 3'd3));
        end
        four     = four_flip ? ~four_raw : four_raw;
        rd_out   = four_bal ? rd_mid : ~rd_mid;
        code     = {six, four};
    end

endmodule
`default_nettype wire

// File: rtl/pcs_transmit_ordered_set.sv
`default_nettype none
// ============================================================================
//  Module   : pcs_transmit_ordered_set
//  Purpose  : 1000BASE-X PCS transmit: GMII tx_en/tx_er/txd to a registered
//             10-bit code-group stream (/I/, /S/, data, /V/, /T/, /R/).
//  Revision : 1.0 - initial release
// ============================================================================
module pcs_transmit_ordered_set
    import pcs_codes_pkg::*;
(
    input  logic       clk,
    input  logic       RESET,
    input  logic       tx_en,
    input  logic       tx_er,
    input  logic [7:0] txd,
    output logic [9:0] tx_code_group,
    output logic       tx_even,
    output logic       rd_pos
);

    tx_state_e  state_q, state_d;
    logic [9:0] cg_q, cg_d;
    logic       even_q, even_d;
    logic       rd_q, rd_d;
    logic [7:0] enc_data;
    logic       enc_k;
    logic [9:0] enc_code;
    logic       enc_rd;

    // Select the next group to emit and the following state
    always_comb begin
        state_d  = state_q;
        enc_data = K28_5_BYTE;
        enc_k    = 1'b1;
        case (state_q)
            ST_IDLE_K: begin
                // A frame starting here replaces the K28.5 with /S/ on the same even slot
                if (tx_en) begin
                    enc_data = K27_7_BYTE;
                    state_d  = ST_DATA;
                end else begin
                    enc_data = K28_5_BYTE;
                    state_d  = ST_IDLE_D;
                end
            end
            ST_IDLE_D: begin
                // /I2/ restores RD- after a K28.5 begun at RD-, /I1/ keeps RD-
                enc_k    = 1'b0;
                enc_data = rd_q ? D16_2_BYTE : D5_6_BYTE;
                state_d  = ST_IDLE_K;
            end
            ST_START: begin
                enc_data = K27_7_BYTE;
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                if (!tx_en) begin
                    enc_data = K29_7_BYTE;
                    state_d  = ST_END_R;
                end else if (tx_er) begin
                    enc_data = K30_7_BYTE;
                end else begin
                    enc_k    = 1'b0;
                    enc_data = txd;
                end
            end
            ST_END_R: begin
                // The /R/ lands even when the current group is odd; pad with a second /R/
                enc_data = K23_7_BYTE;
                state_d  = even_q ? ST_IDLE_K : ST_END_R2;
            end
            ST_END_R2: begin
                enc_data = K23_7_BYTE;
                state_d  = ST_IDLE_K;
            end
            default: begin
                state_d  = ST_IDLE_K;
            end
        endcase
    end

    encoder_8b10b u_encoder (
        .data   (enc_data),
        .is_k   (enc_k),
        .rd_in  (rd_q),
        .code   (enc_code),
        .rd_out (enc_rd)
    );

    // Next register values from the encoder output; parity toggles every clock
    always_comb begin
        cg_d   = enc_code;
        rd_d   = enc_rd;
        even_d = ~even_q;
    end

    // State and output registers; reset presents K28.5 RD- on an even slot
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE_D;
            cg_q    <= K28_5_NEG;
            even_q  <= 1'b1;
            rd_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cg_q    <= cg_d;
            even_q  <= even_d;
            rd_q    <= rd_d;
        end
    end

    assign tx_code_group = cg_q;
    assign tx_even       = even_q;
    assign rd_pos        = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_pcs_transmit_ordered_set.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcs_transmit_ordered_set
//  Purpose  : Self-checking bench for pcs_transmit_ordered_set: vector table
//             for idle/frame sequences, an all-octets frame, and reset abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_transmit_ordered_set;

    localparam logic [9:0] C_K285N = 10'b0011111010;
    localparam logic [9:0] C_K285P = 10'b1100000101;
    localparam logic [9:0] C_K277N = 10'b1101101000;
    localparam logic [9:0] C_K297N = 10'b1011101000;
    localparam logic [9:0] C_K297P = 10'b0100010111;
    localparam logic [9:0] C_K237N = 10'b1110101000;
    localparam logic [9:0] C_K237P = 10'b0001010111;
    localparam logic [9:0] C_K307N = 10'b0111101000;
    localparam logic [9:0] C_K307P = 10'b1000010111;
    localparam logic [9:0] C_D162P = 10'b1001000101;
    localparam logic [9:0] C_D56   = 10'b1010010110;

    typedef struct packed {
        logic [9:0] cg;
        logic       ev;
        logic       rd;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] d;
        exp_t       e;
    } vec_t;

    logic       clk;
    logic       RESET;
    logic       tx_en;
    logic       tx_er;
    logic [7:0] txd;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       rd_pos;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t tbl[31];
    logic m_rd;
    logic m_ev;

    pcs_transmit_ordered_set dut (
        .clk           (clk),
        .RESET         (RESET),
        .tx_en         (tx_en),
        .tx_er         (tx_er),
        .txd           (txd),
        .tx_code_group (tx_code_group),
        .tx_even       (tx_even),
        .rd_pos        (rd_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    // Reference 5b/6b (RD- forms)
    function automatic logic [5:0] ref6(input logic [4:0] x);
        logic [5:0] t[32];
        t = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
              6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
              6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
              6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
              6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
              6'b011110, 6'b101011};
        return t[x];
    endfunction

    // Reference 3b/4b (RD- forms) for .0 to .6
    function automatic logic [3:0] ref4(input logic [2:0] y);
        logic [3:0] t[8];
        t = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
        return t[y];
    endfunction

    // Reference data encoder: returns {rd_after, code}
    function automatic logic [10:0] ref_data(input logic [7:0] b, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s;
        logic [3:0] f;
        logic       r;
        x = b[4:0];
        y = b[7:5];
        s = ref6(x);
        r = rd;
        if ($countones(s) == 4) begin
            if (rd) s = ~s;
            r = ~rd;
        end else if (x == 5'd7 && rd) begin
            s = ~s;
        end
        if (y == 3'd7) begin
            if ((!r && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                ( r && (x == 5'd11 || x == 5'd13 || x == 5'd14)))
                f = r ? 4'b1000 : 4'b0111;
            else
                f = r ? 4'b0001 : 4'b1110;
            r = ~r;
        end else begin
            f = ref4(y);
            if ($countones(f) == 3) begin
                if (r) f = ~f;
                r = ~r;
            end else if (y == 3'd3 && r) begin
                f = ~f;
            end
        end
        return {r, s, f};
    endfunction

    task automatic check_now(input string nm, input exp_t e);
        checks++;
        if ({tx_code_group, tx_even, rd_pos} !== {e.cg, e.ev, e.rd}) begin
            errors++;
            $display("FAIL %s: got cg=%b even=%b rd=%b, expected cg=%b even=%b rd=%b",
                     nm, tx_code_group, tx_even, rd_pos, e.cg, e.ev, e.rd);
        end
    endtask

    // Drive one cycle of inputs, queue its expected group, compare after the edge
    task automatic step(input logic en, input logic er, input logic [7:0] d,
                        input exp_t e, input string nm);
        exp_t got;
        tx_en = en;
        tx_er = er;
        txd   = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            got = exp_q.pop_front();
            check_now(nm, got);
        end
    endtask

    initial begin
        RESET = 1'b0;
        tx_en = 1'b0;
        tx_er = 1'b0;
        txd   = 8'h00;

        // Idle, late start, one-byte frame, two-byte frame, /V/ frame with /I1/
        tbl[0]  = '{1'b0, 1'b1, 8'hAA, '{C_D162P, 1'b0, 1'b0}};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, '{C_K285N, 1'b1, 1'b1}};
        tbl[2]  = '{1'b0, 1'b1, 8'h3C, '{C_D162P, 1'b0, 1'b0}};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, '{C_K285N, 1'b1, 1'b1}};
        tbl[4]  = '{1'b1, 1'b0, 8'h55, '{C_D162P, 1'b0, 1'b0}};
        tbl[5]  = '{1'b1, 1'b0, 8'hD5, '{C_K277N, 1'b1, 1'b0}};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, '{10'b1001110100, 1'b0, 1'b0}};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, '{C_K297N, 1'b1, 1'b0}};
        tbl[8]  = '{1'b1, 1'b0, 8'hFF, '{C_K237N, 1'b0, 1'b0}};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, '{C_K285N, 1'b1, 1'b1}};
        tbl[10] = '{1'b0, 1'b0, 8'h00, '{C_D162P, 1'b0, 1'b0}};
        tbl[11] = '{1'b1, 1'b0, 8'h55, '{C_K277N, 1'b1, 1'b0}};
        tbl[12] = '{1'b1, 1'b0, 8'hF1, '{10'b1000110111, 1'b0, 1'b1}};
        tbl[13] = '{1'b1, 1'b0, 8'hEB, '{10'b1101001000, 1'b1, 1'b0}};
        tbl[14] = '{1'b0, 1'b1, 8'h00, '{C_K297N, 1'b0, 1'b0}};
        tbl[15] = '{1'b1, 1'b0, 8'h00, '{C_K237N, 1'b1, 1'b0}};
        tbl[16] = '{1'b1, 1'b0, 8'h00, '{C_K237N, 1'b0, 1'b0}};
        tbl[17] = '{1'b0, 1'b0, 8'h00, '{C_K285N, 1'b1, 1'b1}};
        tbl[18] = '{1'b0, 1'b0, 8'h00, '{C_D162P, 1'b0, 1'b0}};
        tbl[19] = '{1'b1, 1'b0, 8'h55, '{C_K277N, 1'b1, 1'b0}};
        tbl[20] = '{1'b1, 1'b0, 8'h00, '{10'b1001110100, 1'b0, 1'b0}};
        tbl[21] = '{1'b1, 1'b1, 8'h00, '{C_K307N, 1'b1, 1'b0}};
        tbl[22] = '{1'b1, 1'b0, 8'hE3, '{10'b1100011110, 1'b0, 1'b1}};
        tbl[23] = '{1'b1, 1'b1, 8'h12, '{C_K307P, 1'b1, 1'b1}};
        tbl[24] = '{1'b0, 1'b0, 8'h00, '{C_K297P, 1'b0, 1'b1}};
        tbl[25] = '{1'b0, 1'b0, 8'h00, '{C_K237P, 1'b1, 1'b1}};
        tbl[26] = '{1'b0, 1'b0, 8'h00, '{C_K237P, 1'b0, 1'b1}};
        tbl[27] = '{1'b0, 1'b0, 8'h00, '{C_K285P, 1'b1, 1'b0}};
        tbl[28] = '{1'b0, 1'b0, 8'h00, '{C_D56,   1'b0, 1'b0}};
        tbl[29] = '{1'b0, 1'b0, 8'h00, '{C_K285N, 1'b1, 1'b1}};
        tbl[30] = '{1'b0, 1'b0, 8'h00, '{C_D162P, 1'b0, 1'b0}};

        // Reset hold
        @(posedge clk);
        #1;
        check_now("reset_hold_0", '{C_K285N, 1'b1, 1'b1});
        @(posedge clk);
        #1;
        check_now("reset_hold_1", '{C_K285N, 1'b1, 1'b1});
        RESET = 1'b1;

        for (int i = 0; i < 31; i++) begin
            step(tbl[i].en, tbl[i].er, tbl[i].d, tbl[i].e, $sformatf("row_%0d", i));
        end

        // Frame carrying every octet value, with occasional /V/
        m_rd = 1'b0;
        m_ev = 1'b1;
        step(1'b1, 1'b0, 8'h5A, '{C_K277N, 1'b1, 1'b0}, "octets_start");
        for (int i = 0; i < 256; i++) begin
            logic        er;
            logic [10:0] r;
            exp_t        e;
            logic [7:0]  b;
            b    = i[7:0];
            er   = ((i % 37) == 5);
            m_ev = ~m_ev;
            if (er) begin
                e = '{(m_rd ? C_K307P : C_K307N), m_ev, m_rd};
            end else begin
                r    = ref_data(b, m_rd);
                m_rd = r[10];
                e    = '{r[9:0], m_ev, m_rd};
            end
            step(1'b1, er, b, e, $sformatf("octet_%0d", i));
        end
        m_ev = ~m_ev;
        step(1'b0, 1'b0, 8'h00, '{(m_rd ? C_K297P : C_K297N), m_ev, m_rd}, "octets_T");
        m_ev = ~m_ev;
        step(1'b0, 1'b0, 8'h00, '{(m_rd ? C_K237P : C_K237N), m_ev, m_rd}, "octets_R");
        m_ev = ~m_ev;
        step(1'b0, 1'b0, 8'h00, '{(m_rd ? C_K237P : C_K237N), m_ev, m_rd}, "octets_R2");
        m_ev = ~m_ev;
        step(1'b0, 1'b0, 8'h00, '{(m_rd ? C_K285P : C_K285N), m_ev, ~m_rd}, "octets_K");
        m_rd = ~m_rd;
        m_ev = ~m_ev;
        step(1'b0, 1'b0, 8'h00, '{(m_rd ? C_D162P : C_D56), m_ev, 1'b0}, "octets_Idle_D");

        // Reset asserted in the middle of a frame
        step(1'b1, 1'b0, 8'h55, '{C_K277N, 1'b1, 1'b0}, "abort_S");
        step(1'b1, 1'b0, 8'h00, '{10'b1001110100, 1'b0, 1'b0}, "abort_D0");
        tx_en = 1'b1;
        txd   = 8'hF1;
        #3;
        RESET = 1'b0;
        #1;
        check_now("abort_async", '{C_K285N, 1'b1, 1'b1});
        @(posedge clk);
        #1;
        check_now("abort_hold", '{C_K285N, 1'b1, 1'b1});
        RESET = 1'b1;
        step(1'b0, 1'b0, 8'h00, '{C_D162P, 1'b0, 1'b0}, "abort_first");
        step(1'b0, 1'b0, 8'h00, '{C_K285N, 1'b1, 1'b1}, "abort_K");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
